// File: rtl/sha256_pkg.sv
// SHA-256 constants, round helper functions and the double-hash phase encoding.
// Shared by the round core and the double_sha sequencer.
package sha256_pkg;

    typedef enum logic [1:0] {P1, P2, P3, DONE} phase_e;

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        logic [63:0] t;
        t = {x, x} >> n;
        return t[31:0];
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_round_core.sv
// One SHA-256 compression over 65 cycles: a start cycle doing round 0, rounds 1..63,
// then a feed-forward cycle (done_o high) that registers h_in + a..h into h_out_o.
module sha256_round_core
    import sha256_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [511:0] block_i,
    input  logic [255:0] h_in_i,
    output logic [255:0] h_out_o,
    output logic         done_o
);

    // Word 7 is a (H0), word 0 is h; window word 15 is W[t].
    logic [7:0][31:0]  st_q, st_d, hin_q, cur, hsum, h_out_q;
    logic [15:0][31:0] w_q, w_d, src;
    logic [5:0]        rnd_q;
    logic              run_q, ff_q;
    logic [31:0]       kt, t1, t2;

    always_comb begin
        src  = start_i ? block_i : w_q;
        cur  = start_i ? h_in_i : st_q;
        kt   = K[start_i ? 6'd0 : rnd_q];
        t1   = cur[0] + bsig1(cur[3]) + ch(cur[3], cur[2], cur[1]) + kt + src[15];
        t2   = bsig0(cur[7]) + maj(cur[7], cur[6], cur[5]);
        st_d = {t1 + t2, cur[7], cur[6], cur[5], cur[4] + t1, cur[3], cur[2], cur[1]};
        w_d  = {src[14:0], ssig1(src[1]) + src[6] + ssig0(src[14]) + src[15]};
        hsum = '0;
        for (int i = 0; i < 8; i++) hsum[i] = hin_q[i] + st_q[i];
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            st_q    <= '0;
            w_q     <= '0;
            hin_q   <= '0;
            h_out_q <= '0;
            rnd_q   <= '0;
            run_q   <= 1'b0;
            ff_q    <= 1'b0;
        end else begin
            if (start_i || run_q) begin
                st_q <= st_d;
                w_q  <= w_d;
            end
            if (start_i) begin
                hin_q <= h_in_i;
                rnd_q <= 6'd1;
                run_q <= 1'b1;
            end else if (run_q) begin
                rnd_q <= rnd_q + 6'd1;
                if (rnd_q == 6'd63) begin
                    run_q <= 1'b0;
                    ff_q  <= 1'b1;
                end
            end
            if (ff_q) begin
                h_out_q <= hsum;
                ff_q    <= 1'b0;
            end
        end
    end

    assign h_out_o = h_out_q;
    assign done_o  = ff_q;

endmodule

// File: rtl/double_sha.sv
// SHA-256(SHA-256(M)) over a fixed 80-byte header; fixed 196-edge latency from capture.
// Sequences three compressions on one round core and builds the padded blocks.
module double_sha
    import sha256_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [639:0] block_info,
    output logic         complete,
    output logic [255:0] hash
);

    phase_e         phase_q, phase_d;
    logic [639:0]   msg_q;
    logic           cap_q, start_q, complete_q, core_done;
    logic [255:0]   hash_q, h_in, h_out;
    logic [511:0]   blk;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) phase_q <= P1;
        else        phase_q <= phase_d;
    end

    // Phase advances on the feed-forward edge so the next start sees the new phase.
    always_comb begin
        phase_d = phase_q;
        if (core_done) begin
            case (phase_q)
                P1:      phase_d = P2;
                P2:      phase_d = P3;
                P3:      phase_d = DONE;
                default: phase_d = phase_q;
            endcase
        end
    end

    always_comb begin
        case (phase_q)
            P1: begin
                blk  = msg_q[639:128];
                h_in = IV;
            end
            P2: begin
                blk  = {msg_q[127:0], 1'b1, 319'b0, 64'd640};
                h_in = h_out;
            end
            default: begin
                blk  = {h_out, 1'b1, 191'b0, 64'd256};
                h_in = IV;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            msg_q      <= '0;
            cap_q      <= 1'b0;
            start_q    <= 1'b0;
            complete_q <= 1'b0;
            hash_q     <= '0;
        end else begin
            start_q <= !cap_q || (core_done && phase_q != P3);
            if (!cap_q) begin
                msg_q <= block_info;
                cap_q <= 1'b1;
            end
            if (phase_q == DONE && !complete_q) begin
                complete_q <= 1'b1;
                hash_q     <= h_out;
            end
        end
    end

    sha256_round_core u_core (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_q),
        .block_i (blk),
        .h_in_i  (h_in),
        .h_out_o (h_out),
        .done_o  (core_done)
    );

    assign complete = complete_q;
    assign hash     = hash_q;

endmodule

// File: tb/tb_double_sha.sv
// Bench for double_sha: ten instances, random headers, byte-level software SHA-256 model.
module tb_double_sha;

    localparam int N = 10;
    localparam logic [639:0] GEN_MSG = {32'h01000000, 256'h0,
        256'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a,
        32'h29ab5f49, 32'hffff001d, 32'h1dac2b7c};
    localparam logic [255:0] GEN_HASH = 256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000;

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
    localparam logic [31:0] IVT [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic [N-1:0][639:0]   bi;
    logic [N-1:0]          cmp;
    logic [N-1:0][255:0]   hs;
    int                    total = 0;
    int                    bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        double_sha u_dut (
            .clk_i      (clk),
            .rst_i      (rst_n),
            .block_info (bi[g]),
            .complete   (cmp[g]),
            .hash       (hs[g])
        );
    end

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        logic [63:0] t;
        t = {x, x} >> n;
        return t[31:0];
    endfunction

    // Textbook SHA-256 over an arbitrary byte string, with generic padding.
    function automatic logic [255:0] sha256_bytes(input logic [7:0] m[$]);
        logic [7:0]  p[$];
        logic [31:0] h[8];
        logic [31:0] w[64];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
        longint unsigned nbits;
        p = m;
        nbits = 64'(m.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(8'(nbits >> (8 * i)));
        for (int i = 0; i < 8; i++) h[i] = IVT[i];
        for (int bk = 0; bk < p.size() / 64; bk++) begin
            for (int t = 0; t < 16; t++)
                w[t] = {p[64*bk+4*t], p[64*bk+4*t+1], p[64*bk+4*t+2], p[64*bk+4*t+3]};
            for (int t = 16; t < 64; t++) begin
                s0 = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
                s1 = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
                w[t] = w[t-16] + s0 + w[t-7] + s1;
            end
            a = h[0]; b = h[1]; c = h[2]; d = h[3]; e = h[4]; f = h[5]; g = h[6]; hh = h[7];
            for (int t = 0; t < 64; t++) begin
                t1 = hh + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + KT[t] + w[t];
                t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
                hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
            end
            h[0] += a; h[1] += b; h[2] += c; h[3] += d; h[4] += e; h[5] += f; h[6] += g; h[7] += hh;
        end
        return {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
    endfunction

    function automatic logic [255:0] dsha(input logic [639:0] msg);
        logic [7:0]   q[$];
        logic [255:0] d1;
        for (int i = 0; i < 80; i++) q.push_back(msg[639-8*i -: 8]);
        d1 = sha256_bytes(q);
        q.delete();
        for (int i = 0; i < 32; i++) q.push_back(d1[255-8*i -: 8]);
        return sha256_bytes(q);
    endfunction

    function automatic logic [639:0] rand_hdr();
        logic [639:0] m;
        for (int i = 0; i < 20; i++) m[32*i +: 32] = $urandom;
        return m;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
    endtask

    // Returns just after edge 0 (the capture edge).
    task automatic release_rst();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic edges(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (cmp[0] !== 1'b0) begin bad++; $display("FAIL reset_complete: got %b want 0", cmp[0]); end
        total++;
        if (hs[0] !== 256'h0) begin bad++; $display("FAIL reset_hash: got %h want 0", hs[0]); end
        edges(3);
        total++;
        if (cmp !== '0) begin bad++; $display("FAIL reset_hold: got %b want 0", cmp); end
    endtask

    task automatic test_genesis_latency();
        int early;
        int unstable;
        logic [255:0] held;
        early = -1;
        unstable = 0;
        do_reset();
        bi[0] = GEN_MSG;
        release_rst();
        for (int e = 1; e <= 195; e++) begin
            edges(1);
            if ((cmp[0] !== 1'b0 || hs[0] !== 256'h0) && early < 0) early = e;
        end
        total++;
        if (early >= 0) begin bad++; $display("FAIL latency_early: output seen at edge %0d want 196", early); end
        edges(1);
        total++;
        if (cmp[0] !== 1'b1) begin bad++; $display("FAIL latency_196: got complete=%b want 1", cmp[0]); end
        total++;
        if (hs[0] !== GEN_HASH) begin bad++; $display("FAIL genesis_hash: got %h want %h", hs[0], GEN_HASH); end
        held = hs[0];
        for (int e = 0; e < 100; e++) begin
            edges(1);
            if (cmp[0] !== 1'b1 || hs[0] !== held) unstable++;
        end
        total++;
        if (unstable != 0) begin bad++; $display("FAIL done_hold: got %0d unstable cycles want 0", unstable); end
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (cmp[0] !== 1'b0 || hs[0] !== 256'h0) begin
            bad++;
            $display("FAIL async_reset: got complete=%b hash=%h want 0/0", cmp[0], hs[0]);
        end
        #1 rst_n = 1'b1;
    endtask

    task automatic test_input_isolation();
        logic [639:0] m;
        m = rand_hdr();
        do_reset();
        bi[0] = m;
        release_rst();
        edges(5);
        bi[0][31:0] = ~m[31:0];
        edges(191);
        total++;
        if (cmp[0] !== 1'b1 || hs[0] !== dsha(m)) begin
            bad++;
            $display("FAIL input_isolation: got %b/%h want 1/%h", cmp[0], hs[0], dsha(m));
        end
    endtask

    task automatic test_mid_reset();
        logic [639:0] m;
        m = rand_hdr();
        do_reset();
        bi[0] = m;
        release_rst();
        edges(100);
        rst_n = 1'b0;
        #1;
        total++;
        if (cmp[0] !== 1'b0 || hs[0] !== 256'h0) begin
            bad++;
            $display("FAIL mid_reset_clear: got %b/%h want 0/0", cmp[0], hs[0]);
        end
        m[31:0] = $urandom;
        bi[0] = m;
        @(negedge clk);
        release_rst();
        edges(195);
        total++;
        if (cmp[0] !== 1'b0) begin bad++; $display("FAIL mid_reset_early: got complete=%b at edge 195 want 0", cmp[0]); end
        edges(1);
        total++;
        if (cmp[0] !== 1'b1 || hs[0] !== dsha(m)) begin
            bad++;
            $display("FAIL mid_reset_rerun: got %b/%h want 1/%h", cmp[0], hs[0], dsha(m));
        end
    endtask

    task automatic test_reset_wins();
        do_reset();
        bi[0] = rand_hdr();
        release_rst();
        edges(195);
        rst_n = 1'b0;
        edges(1);
        total++;
        if (cmp[0] !== 1'b0 || hs[0] !== 256'h0) begin
            bad++;
            $display("FAIL reset_wins: got %b/%h want 0/0", cmp[0], hs[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [639:0] base;
        base = rand_hdr();
        for (int r = 0; r < 2; r++) begin
            do_reset();
            for (int i = 0; i < N; i++) bi[i] = {base[639:32], 32'(i + 10 * r)};
            release_rst();
            edges(196);
            for (int i = 0; i < N; i++) begin
                total++;
                if (cmp[i] !== 1'b1 || hs[i] !== dsha(bi[i])) begin
                    bad++;
                    $display("FAIL b2b_nonce%0d: got %b/%h want 1/%h", i + 10 * r, cmp[i], hs[i], dsha(bi[i]));
                end
            end
        end
    endtask

    initial begin
        bi = '0;
        test_reset();
        test_genesis_latency();
        test_async_reset();
        test_input_isolation();
        test_mid_reset();
        test_reset_wins();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
